// File: rtl/frog_motion_if.sv
// Bundles the frame tick, buttons, hazard input and sprite-facing outputs of frog_motion.
// The master modport drives stimulus, and frog_motion sits on the slave side.
interface frog_motion_if;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       kill;
    logic [9:0] frog_x;
    logic [9:0] frog_y;
    logic [1:0] facing;
    logic       hopping;
    logic       dead;
    logic       hop_done;
    logic       fwd_hop;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, kill,
        input  frog_x, frog_y, facing, hopping, dead, hop_done, fwd_hop
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, kill,
        output frog_x, frog_y, facing, hopping, dead, hop_done, fwd_hop
    );
endinterface

// File: rtl/frog_motion.sv
// Frog movement controller: button edges become animated grid hops, with death hold and respawn.
// Define FROG_HOP_QUEUE_EN to buffer one button edge that arrives while a hop is running.
module frog_motion #(
    parameter int GRID        = 32,
    parameter int HOP_FRAMES  = 8,
    parameter int FIELD_W     = 640,
    parameter int FIELD_H     = 480,
    parameter int START_X     = 304,
    parameter int START_Y     = 448,
    parameter int DEAD_FRAMES = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    frog_motion_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_HOP, S_DEAD} state_e;
    typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11} dir_e;

    localparam int          CW      = $clog2(HOP_FRAMES + 1);
    localparam int          DW      = $clog2(DEAD_FRAMES + 1);
    localparam logic [9:0]  STEP_V  = 10'(GRID / HOP_FRAMES);
    localparam logic [10:0] GRID_W  = 11'(GRID);
    localparam logic [10:0] X_LIM   = 11'(FIELD_W - GRID);
    localparam logic [10:0] Y_LIM   = 11'(FIELD_H - GRID);

    state_e          state_q, state_d;
    dir_e            facing_q, facing_d, hop_dir_q, hop_dir_d, pend_dir_q, pend_dir_d;
    logic            pend_vld_q, pend_vld_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [3:0]      btn_prev_q;
    logic            hopping_q, hopping_d, dead_q, dead_d;
    logic            hop_done_q, hop_done_d, fwd_hop_q, fwd_hop_d;
`ifdef FROG_HOP_QUEUE_EN
    dir_e            q_dir_q, q_dir_d;
    logic            q_vld_q, q_vld_d;
`endif

    logic [3:0] btn_now, rise;
    logic       edge_vld, in_bounds;
    dir_e       edge_dir;

    assign btn_now  = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
    assign rise     = btn_now & ~btn_prev_q;
    assign edge_vld = |rise;

    // Simultaneous edges resolve up > down > left > right.
    always_comb begin
        edge_dir = DIR_RIGHT;
        if (rise[3])      edge_dir = DIR_UP;
        else if (rise[2]) edge_dir = DIR_DOWN;
        else if (rise[1]) edge_dir = DIR_LEFT;
    end

    always_comb begin
        in_bounds = 1'b0;
        case (pend_dir_q)
            DIR_UP:    in_bounds = {1'b0, y_q} >= GRID_W;
            DIR_DOWN:  in_bounds = {1'b0, y_q} + GRID_W <= Y_LIM;
            DIR_LEFT:  in_bounds = {1'b0, x_q} >= GRID_W;
            DIR_RIGHT: in_bounds = {1'b0, x_q} + GRID_W <= X_LIM;
            default:   in_bounds = 1'b0;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        facing_d   = facing_q;
        hop_dir_d  = hop_dir_q;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        hop_done_d = 1'b0;
        fwd_hop_d  = 1'b0;
`ifdef FROG_HOP_QUEUE_EN
        q_dir_d    = q_dir_q;
        q_vld_d    = q_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.frame_tick && pend_vld_q) begin
                    facing_d   = pend_dir_q;
                    pend_vld_d = 1'b0;
                    if (in_bounds) begin
                        state_d   = S_HOP;
                        hop_dir_d = pend_dir_q;
                        cnt_d     = CW'(HOP_FRAMES);
                    end
                end
                if (edge_vld) begin
                    pend_vld_d = 1'b1;
                    pend_dir_d = edge_dir;
                end
            end
            S_HOP: begin
`ifdef FROG_HOP_QUEUE_EN
                if (edge_vld) begin
                    q_vld_d = 1'b1;
                    q_dir_d = edge_dir;
                end
`endif
                if (bus.frame_tick) begin
                    case (hop_dir_q)
                        DIR_UP:    y_d = y_q - STEP_V;
                        DIR_DOWN:  y_d = y_q + STEP_V;
                        DIR_LEFT:  x_d = x_q - STEP_V;
                        default:   x_d = x_q + STEP_V;
                    endcase
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d    = S_IDLE;
                        hop_done_d = 1'b1;
                        fwd_hop_d  = (hop_dir_q == DIR_UP);
`ifdef FROG_HOP_QUEUE_EN
                        pend_vld_d = q_vld_q || edge_vld;
                        pend_dir_d = edge_vld ? edge_dir : q_dir_q;
                        q_vld_d    = 1'b0;
`endif
                    end
                end
            end
            S_DEAD: begin
                if (bus.frame_tick) begin
                    dcnt_d = dcnt_q - DW'(1);
                    if (dcnt_q == DW'(1)) begin
                        state_d  = S_IDLE;
                        x_d      = 10'(START_X);
                        y_d      = 10'(START_Y);
                        facing_d = DIR_UP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Kill outranks everything, including a completing tick: position and facing freeze.
        if (bus.kill && state_q != S_DEAD) begin
            state_d    = S_DEAD;
            dcnt_d     = DW'(DEAD_FRAMES);
            pend_vld_d = 1'b0;
            facing_d   = facing_q;
            x_d        = x_q;
            y_d        = y_q;
            hop_done_d = 1'b0;
            fwd_hop_d  = 1'b0;
`ifdef FROG_HOP_QUEUE_EN
            q_vld_d    = 1'b0;
`endif
        end

        hopping_d = (state_d == S_HOP);
        dead_d    = (state_d == S_DEAD);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            facing_q   <= DIR_UP;
            hop_dir_q  <= DIR_UP;
            pend_dir_q <= DIR_UP;
            pend_vld_q <= 1'b0;
            x_q        <= 10'(START_X);
            y_q        <= 10'(START_Y);
            cnt_q      <= '0;
            dcnt_q     <= '0;
            btn_prev_q <= '0;
            hopping_q  <= 1'b0;
            dead_q     <= 1'b0;
            hop_done_q <= 1'b0;
            fwd_hop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            facing_q   <= facing_d;
            hop_dir_q  <= hop_dir_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            btn_prev_q <= btn_now;
            hopping_q  <= hopping_d;
            dead_q     <= dead_d;
            hop_done_q <= hop_done_d;
            fwd_hop_q  <= fwd_hop_d;
        end
    end

`ifdef FROG_HOP_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_dir_q <= DIR_UP;
            q_vld_q <= 1'b0;
        end else begin
            q_dir_q <= q_dir_d;
            q_vld_q <= q_vld_d;
        end
    end
`endif

    assign bus.frog_x   = x_q;
    assign bus.frog_y   = y_q;
    assign bus.facing   = facing_q;
    assign bus.hopping  = hopping_q;
    assign bus.dead     = dead_q;
    assign bus.hop_done = hop_done_q;
    assign bus.fwd_hop  = fwd_hop_q;
endmodule

// File: tb/tb_frog_motion.sv
// Directed bench for frog_motion: reset, hops, bounds rejection, kill/respawn, priority and queueing.
// Expected values are hand-computed from default parameters (GRID 32, 8 frames per hop, STEP 4).
module tb_frog_motion;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    frog_motion_if bus ();

    frog_motion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // One frame tick: high across exactly one rising edge; returns at the following falling edge.
    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    // Button mask order: {up, down, left, right}.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = m;
        @(negedge clk);
        {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.btn_up     = 1'b0;
        bus.btn_down   = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.kill       = 1'b0;
        #23;
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_x", int'(bus.frog_x), 304);
        check("rst_y", int'(bus.frog_y), 448);
        check("rst_facing", int'(bus.facing), 0);
        check("rst_hopping", int'(bus.hopping), 0);
        check("rst_dead", int'(bus.dead), 0);
        check("rst_hop_done", int'(bus.hop_done), 0);

        // Down from the bottom row is out of bounds: only facing changes.
        press(4'b0100);
        tick();
        check("down_rej_facing", int'(bus.facing), 1);
        check("down_rej_y", int'(bus.frog_y), 448);
        check("down_rej_hopping", int'(bus.hopping), 0);

        // Up hop killed after three steps, then the 30-tick death hold.
        press(4'b1000);
        tick();
        check("kill_accept_hopping", int'(bus.hopping), 1);
        check("kill_accept_facing", int'(bus.facing), 0);
        for (int i = 1; i <= 3; i++) tick();
        check("kill_pre_y", int'(bus.frog_y), 436);
        @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_dead", int'(bus.dead), 1);
        check("kill_hopping", int'(bus.hopping), 0);
        check("kill_y_frozen", int'(bus.frog_y), 436);
        for (int i = 1; i <= 29; i++) begin
            tick();
            if (i == 8) begin
                check("dead_y_frozen", int'(bus.frog_y), 436);
                check("dead_no_hop_done", int'(bus.hop_done), 0);
            end
        end
        check("dead_tick29", int'(bus.dead), 1);
        tick();
        check("respawn_dead", int'(bus.dead), 0);
        check("respawn_x", int'(bus.frog_x), 304);
        check("respawn_y", int'(bus.frog_y), 448);
        check("respawn_facing", int'(bus.facing), 0);

        // Full up hop: 448 -> 416 in steps of 4, hop_done/fwd_hop pulse on the final tick.
        press(4'b1000);
        tick();
        check("up_accept_hopping", int'(bus.hopping), 1);
        check("up_accept_y", int'(bus.frog_y), 448);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("up_y_%0d", i), int'(bus.frog_y), 448 - 4 * i);
            check($sformatf("up_hop_done_%0d", i), int'(bus.hop_done), (i == 8) ? 1 : 0);
            check($sformatf("up_hopping_%0d", i), int'(bus.hopping), (i == 8) ? 0 : 1);
        end
        check("up_fwd_hop", int'(bus.fwd_hop), 1);
        @(negedge clk);
        check("up_hop_done_single", int'(bus.hop_done), 0);
        check("up_fwd_hop_single", int'(bus.fwd_hop), 0);

        // Up and left on the same cycle: up wins, left is discarded.
        press(4'b1010);
        tick();
        check("prio_facing", int'(bus.facing), 0);
        check("prio_hopping", int'(bus.hopping), 1);
        for (int i = 1; i <= 8; i++) tick();
        check("prio_y", int'(bus.frog_y), 384);
        tick();
        check("prio_no_left_hopping", int'(bus.hopping), 0);
        check("prio_no_left_x", int'(bus.frog_x), 304);
        check("prio_no_left_facing", int'(bus.facing), 0);

        // Left pressed mid-hop.
        press(4'b1000);
        tick();
        tick();
        press(4'b0010);
        for (int i = 1; i <= 7; i++) tick();
        check("q_up_y", int'(bus.frog_y), 352);
        check("q_up_hopping", int'(bus.hopping), 0);
        tick();
`ifdef FROG_HOP_QUEUE_EN
        check("q_left_hopping", int'(bus.hopping), 1);
        check("q_left_facing", int'(bus.facing), 2);
        for (int i = 1; i <= 8; i++) tick();
        check("q_left_x", int'(bus.frog_x), 272);
`else
        check("q_left_hopping", int'(bus.hopping), 0);
        check("q_left_facing", int'(bus.facing), 0);
        for (int i = 1; i <= 8; i++) tick();
        check("q_left_x", int'(bus.frog_x), 304);
`endif
        check("q_left_y", int'(bus.frog_y), 352);

        // Asynchronous reset mid-hop, checked between clock edges.
        press(4'b0001);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", int'(bus.frog_x), 304);
        check("async_rst_y", int'(bus.frog_y), 448);
        check("async_rst_facing", int'(bus.facing), 0);
        check("async_rst_hopping", int'(bus.hopping), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", int'(bus.hopping), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
